// File: rtl/servant_reset_seq.sv
// Staged reset sequencer. It waits for a stable PLL lock and a released button,
// then releases the peripheral reset, and releases the CPU reset a fixed delay later.
module servant_reset_seq #(
   parameter int SYNC_STAGES     = 2,
   parameter int HOLD_CYCLES     = 1024,
   parameter int STAGGER_CYCLES  = 16,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_locked,
   input  logic       i_btn,
   input  logic       i_clr,
   output logic       o_rst_periph,
   output logic       o_rst_cpu,
   output logic       o_ready,
   output logic       o_lock_lost,
   output logic [7:0] o_loss_cnt
);

   localparam int MAX_SEQ = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
   localparam int SEQ_W   = $clog2(MAX_SEQ + 1);
   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [SEQ_W-1:0] HOLD_LAST    = SEQ_W'(HOLD_CYCLES - 1);
   localparam logic [SEQ_W-1:0] STAGGER_LAST = SEQ_W'(STAGGER_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {S_WAIT, S_STABLE, S_RELP, S_RUN} state_e;

   logic [SYNC_STAGES-1:0] lock_sync_q, btn_sync_q;
   logic                   lock_s, btn_s, go, loss_evt;
   logic                   btn_db_q, btn_db_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   state_e                 state_q, state_d;
   logic [SEQ_W-1:0]       seq_cnt_q, seq_cnt_d;
   logic                   rst_periph_q, rst_periph_d;
   logic                   rst_cpu_q, rst_cpu_d;
   logic                   ready_q, ready_d;
   logic                   lock_lost_q, lock_lost_d;
   logic [7:0]             loss_cnt_q, loss_cnt_d;

   assign lock_s = lock_sync_q[SYNC_STAGES-1];
   assign btn_s  = btn_sync_q[SYNC_STAGES-1];
   assign go     = lock_s & ~btn_db_q;

   // In RELP/RUN lock_s was necessarily high last cycle, so a low here is a falling edge.
   assign loss_evt = ~lock_s & ((state_q == S_RELP) | (state_q == S_RUN));

   always_comb begin
      btn_db_d = btn_db_q;
      db_cnt_d = '0;
      if (btn_s != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = ~btn_db_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      seq_cnt_d = seq_cnt_q + SEQ_W'(1);
      case (state_q)
         S_WAIT: begin
            if (go) state_d = S_STABLE;
         end
         S_STABLE: begin
            if (!go)                          state_d = S_WAIT;
            else if (seq_cnt_q == HOLD_LAST)  state_d = S_RELP;
         end
         S_RELP: begin
            if (!go)                             state_d = S_WAIT;
            else if (seq_cnt_q == STAGGER_LAST)  state_d = S_RUN;
         end
         S_RUN: begin
            if (!go) state_d = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
      if (state_d != state_q || state_q == S_WAIT || state_q == S_RUN) seq_cnt_d = '0;

      rst_periph_d = (state_d == S_WAIT) || (state_d == S_STABLE);
      rst_cpu_d    = (state_d != S_RUN);
      ready_d      = (state_d == S_RUN);
   end

   // A clear and a loss in the same cycle leave exactly one recorded event.
   always_comb begin
      lock_lost_d = i_clr ? 1'b0 : lock_lost_q;
      loss_cnt_d  = i_clr ? 8'd0 : loss_cnt_q;
      if (loss_evt) begin
         lock_lost_d = 1'b1;
         if (loss_cnt_d != 8'hFF) loss_cnt_d = loss_cnt_d + 8'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lock_sync_q  <= '0;
         btn_sync_q   <= '0;
         btn_db_q     <= 1'b0;
         db_cnt_q     <= '0;
         state_q      <= S_WAIT;
         seq_cnt_q    <= '0;
         rst_periph_q <= 1'b1;
         rst_cpu_q    <= 1'b1;
         ready_q      <= 1'b0;
         lock_lost_q  <= 1'b0;
         loss_cnt_q   <= '0;
      end else begin
         lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], i_locked};
         btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], i_btn};
         btn_db_q     <= btn_db_d;
         db_cnt_q     <= db_cnt_d;
         state_q      <= state_d;
         seq_cnt_q    <= seq_cnt_d;
         rst_periph_q <= rst_periph_d;
         rst_cpu_q    <= rst_cpu_d;
         ready_q      <= ready_d;
         lock_lost_q  <= lock_lost_d;
         loss_cnt_q   <= loss_cnt_d;
      end
   end

   assign o_rst_periph = rst_periph_q;
   assign o_rst_cpu    = rst_cpu_q;
   assign o_ready      = ready_q;
   assign o_lock_lost  = lock_lost_q;
   assign o_loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_servant_reset_seq.sv
// Directed bench for servant_reset_seq: a vector table for the main sequence plus
// hand-written sequences for glitches, saturation, clear collision and async reset.
module tb_servant_reset_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       locked, btn, clr;
   logic       rst_periph, rst_cpu, ready, lock_lost;
   logic [7:0] loss_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   servant_reset_seq #(
      .SYNC_STAGES    (2),
      .HOLD_CYCLES    (8),
      .STAGGER_CYCLES (4),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_locked    (locked),
      .i_btn       (btn),
      .i_clr       (clr),
      .o_rst_periph(rst_periph),
      .o_rst_cpu   (rst_cpu),
      .o_ready     (ready),
      .o_lock_lost (lock_lost),
      .o_loss_cnt  (loss_cnt)
   );

   // n: edges to advance with the given inputs held; then expected outputs.
   typedef struct packed {
      logic [7:0] n;
      logic       lk, bt, cl;
      logic       ep, ec, er, el;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl [22];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ep, input logic ec, input logic er,
                          input logic el, input logic [7:0] ecnt);
      chk({tag, ".periph"}, {31'd0, rst_periph}, {31'd0, ep});
      chk({tag, ".cpu"},    {31'd0, rst_cpu},    {31'd0, ec});
      chk({tag, ".ready"},  {31'd0, ready},      {31'd0, er});
      chk({tag, ".lost"},   {31'd0, lock_lost},  {31'd0, el});
      chk({tag, ".cnt"},    {24'd0, loss_cnt},   {24'd0, ecnt});
   endtask

   initial begin
      //            n  lk bt cl  ep ec er el cnt
      tbl[0]  = '{8'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}; // edge 10: held
      tbl[1]  = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}; // edge 11: periph out
      tbl[2]  = '{8'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}; // edge 14
      tbl[3]  = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}; // edge 15: RUN
      tbl[4]  = '{8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}; // lock drop, 2 edges
      tbl[5]  = '{8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1}; // 3rd edge: WAIT, loss
      tbl[6]  = '{8'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1}; // relock
      tbl[7]  = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
      tbl[8]  = '{8'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
      tbl[9]  = '{8'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}; // bounce 1
      tbl[10] = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}; // bounce 0
      tbl[11] = '{8'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}; // bounce 1
      tbl[12] = '{8'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}; // still RUN
      tbl[13] = '{8'd4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}; // held 4 cycles
      tbl[14] = '{8'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}; // edges e+4,e+5
      tbl[15] = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1}; // e+6: WAIT, no count
      tbl[16] = '{8'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1}; // e+17
      tbl[17] = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1}; // e+18
      tbl[18] = '{8'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
      tbl[19] = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}; // e+22: RUN
      tbl[20] = '{8'd1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}; // clear
      tbl[21] = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};

      rst_n  = 1'b0;
      locked = 1'b0;
      btn    = 1'b0;
      clr    = 1'b0;
      repeat (3) tick();
      chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         locked = tbl[i].lk;
         btn    = tbl[i].bt;
         clr    = tbl[i].cl;
         repeat (int'(tbl[i].n)) tick();
         chk_all($sformatf("vec%0d", i), tbl[i].ep, tbl[i].ec, tbl[i].er, tbl[i].el, tbl[i].cnt);
      end
      clr = 1'b0;

      // 300 lock losses from RUN; count must stop at 255.
      for (int k = 1; k <= 300; k++) begin
         locked = 1'b0;
         repeat (3) tick();
         locked = 1'b1;
         repeat (15) tick();
         if (k == 254) chk("sat.254", {24'd0, loss_cnt}, 32'd254);
         if (k == 255) chk("sat.255", {24'd0, loss_cnt}, 32'd255);
      end
      chk("sat.300", {24'd0, loss_cnt}, 32'd255);
      chk("sat.ready", {31'd0, ready}, 32'd1);

      // Clear coincides with the loss-event edge.
      locked = 1'b0;
      repeat (2) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk_all("clrloss", 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);

      // Re-lock into RELP, then async reset between edges.
      locked = 1'b1;
      repeat (12) tick();
      chk("relp.periph", {31'd0, rst_periph}, 32'd0);
      chk("relp.cpu",    {31'd0, rst_cpu},    32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("restart.e10", {31'd0, rst_periph}, 32'd1);
      tick();
      chk_all("restart.e11", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

      // One-cycle lock glitch at edge 6 during STABLE restarts the hold.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      locked = 1'b1;
      repeat (5) tick();
      locked = 1'b0;
      tick();
      locked = 1'b1;
      repeat (10) tick();
      chk_all("glitch.e16", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      tick();
      chk_all("glitch.e17", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/servant_reset_seq.md
Name: servant_reset_seq

Overview:
- Sits directly downstream of the board clock generator, in the generated system-clock domain.
- Consumes the raw PLL lock indication and a push-button reset. Produces staged, glitch-free reset releases: peripherals first, CPU a fixed delay later.
- Records lock-loss events for diagnostics and re-sequences reset whenever lock drops or the button is pressed.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for i_locked and i_btn; legal range >=2.
- HOLD_CYCLES, 1024: cycles synchronized lock must stay high before o_rst_periph releases; legal range >=1.
- STAGGER_CYCLES, 16: cycles between o_rst_periph release and o_rst_cpu release; legal range >=1.
- DEBOUNCE_CYCLES, 65536: consecutive stable samples needed to change debounced button state; legal range >=1.

Ports:
- i_clk  input  1  generated system clock
- i_rst_n  input  1  reset; asynchronous, active-low
- i_locked  input  1  PLL lock, asynchronous to i_clk
- i_btn  input  1  push-button reset request, active-high, asynchronous, may bounce
- i_clr  input  1  synchronous clear of lock-loss status
- o_rst_periph  output  1  peripheral reset, active-high, registered
- o_rst_cpu  output  1  CPU reset, active-high, registered
- o_ready  output  1  high only in RUN, registered
- o_lock_lost  output  1  sticky lock-loss flag
- o_loss_cnt  output  8  saturating lock-loss event count

Behaviour:
- Async reset (i_rst_n low):
  - State WAIT; all counters and synchronizer flops 0; debounced button 0.
  - o_rst_periph=1, o_rst_cpu=1, o_ready=0, o_lock_lost=0, o_loss_cnt=0.
- Deassertion of i_rst_n is externally synchronized; no requirement on the first edge beyond normal WAIT behaviour.
- lock_s / btn_s: i_locked and i_btn, each through a SYNC_STAGES flop chain.
- Debouncer:
  - Counter restarts whenever btn_s differs from btn_db.
  - btn_db toggles when btn_s has differed for DEBOUNCE_CYCLES consecutive cycles.
  - A single-cycle disagreement resets the count.
- go = lock_s AND NOT btn_db.
- Sequence counter width is clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1). It clears on every state change.
- FSM states:
  - WAIT: both resets high, ready 0. go=1 -> STABLE, counter=0.
  - STABLE: both resets high. go=0 -> WAIT. Counter==HOLD_CYCLES-1 -> RELP and o_rst_periph falls on the same edge. Otherwise counter+1.
  - RELP: periph released, cpu held. go=0 -> WAIT. Counter==STAGGER_CYCLES-1 -> RUN; o_rst_cpu falls and o_ready rises on the same edge.
  - RUN: both released, ready 1. go=0 -> WAIT.
- All outputs are registered from next-state, so they change on the transition edge. Any transition to WAIT reasserts both resets and drops ready on that edge.
- Release latency: with the first i_locked=1 sample at edge 1, o_rst_periph falls at edge SYNC_STAGES+1+HOLD_CYCLES. o_rst_cpu falls STAGGER_CYCLES edges later.
- Lock-drop latency: from the first i_locked=0 sample to both resets high is SYNC_STAGES+1 edges.
- Lock-loss event: lock_s falls while state is RELP or RUN.
  - Sets o_lock_lost.
  - Increments o_loss_cnt, saturating at 255.
  - Loss during WAIT or STABLE is not counted.
  - A button-induced exit is not counted.
- i_clr: clears o_lock_lost and o_loss_cnt. If a loss event occurs in the same cycle, result is o_lock_lost=1, o_loss_cnt=1.
- Simultaneous go drop and counter terminal value: go drop wins, next state WAIT.
- Lock chatter during STABLE restarts the full HOLD_CYCLES count.
- Button held indefinitely keeps the block in WAIT. After release, the debounce period plus the full sequence must elapse before reset releases.

Test Plan:
(SYNC_STAGES=2, HOLD_CYCLES=8, STAGGER_CYCLES=4, DEBOUNCE_CYCLES=4)
- Reset then i_locked=1 from edge 1:
  - o_rst_periph falls at edge 11.
  - o_rst_cpu falls and o_ready rises at edge 15.
  - o_loss_cnt stays 0.
- Lock glitch low at edge 6 for 1 cycle:
  - Both resets stay high.
  - o_rst_periph release moves to 11 edges after the glitch clears.
  - No loss counted.
- In RUN, drop i_locked:
  - Both resets high and o_ready 0 three edges after the first low sample.
  - o_lock_lost=1, o_loss_cnt=1.
  - Re-lock re-runs the full sequence.
- In RUN:
  - i_btn bounce 1,0,1 (1 cycle each) -> no effect.
  - i_btn held 4 cycles -> resets reassert 2+4+1 edges after the first high sample; o_loss_cnt unchanged.
- 300 lock-loss events from RUN -> o_loss_cnt saturates at 255.
- i_clr in the same cycle as a loss event -> o_loss_cnt=1, o_lock_lost=1.
- Assert i_rst_n low mid-RELP:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - Status cleared; sequence restarts after release.
